// File: rtl/gpio_bank_ctrl.sv
// Purpose : N-bank tristate GPIO controller: per-pin OUT/OE registers, synchronised
//           and debounced inputs, edge-triggered sticky interrupts, one registered irq.
// Latency : request accepted at edge k, response valid from k+1; pad writes visible from k+1;
//           pad change reaches IN after SYNC_STAGES + DEBOUNCE_CYC edges.
// Backpressure: one outstanding transaction; req_ready = !rsp_valid | rsp_ready, and the
//           response (rsp_valid/rsp_rdata) is held until rsp_ready.
//
// Ports:
//   clk, rst                    clock, asynchronous active-high reset
//   req_valid/req_ready         register request handshake
//   req_we/req_bank/req_reg     write enable, bank index, register select
//   req_wdata                   write data (one bank wide)
//   rsp_valid/rsp_ready         response handshake
//   rsp_rdata                   read data (0 for writes and unmapped addresses)
//   pad_in/pad_out/pad_oe       pad levels in, drive values out, output enables
//   irq                         registered OR of all pending bits
//
// Register map per bank: 0 OUT, 1 OE, 2 IN (ro), 3 RISE_EN, 4 FALL_EN, 5 PEND (W1C), 6-7 reserved.
module gpio_bank_ctrl #(
  parameter int BANK_W       = 36,
  parameter int N_BANKS      = 2,
  parameter int SYNC_STAGES  = 2,
  parameter int DEBOUNCE_CYC = 16,
  localparam int BW          = (N_BANKS > 1) ? $clog2(N_BANKS) : 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        req_valid,
  output logic                        req_ready,
  input  logic                        req_we,
  input  logic [BW-1:0]               req_bank,
  input  logic [2:0]                  req_reg,
  input  logic [BANK_W-1:0]           req_wdata,
  output logic                        rsp_valid,
  input  logic                        rsp_ready,
  output logic [BANK_W-1:0]           rsp_rdata,
  input  logic [N_BANKS*BANK_W-1:0]   pad_in,
  output logic [N_BANKS*BANK_W-1:0]   pad_out,
  output logic [N_BANKS*BANK_W-1:0]   pad_oe,
  output logic                        irq
);

  localparam int TOT = N_BANKS * BANK_W;
  // Counter only needs to reach DEBOUNCE_CYC-1; the accepting cycle resets it.
  localparam int CW  = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;

  logic [TOT-1:0]    out_q, out_d;
  logic [TOT-1:0]    oe_q, oe_d;
  logic [TOT-1:0]    in_q, in_d;
  logic [TOT-1:0]    rise_q, rise_d;
  logic [TOT-1:0]    fall_q, fall_d;
  logic [TOT-1:0]    pend_q, pend_d;
  logic [TOT-1:0]    sync_q [SYNC_STAGES];
  logic [TOT-1:0]    sync_d [SYNC_STAGES];
  logic [CW-1:0]     cnt_q [TOT];
  logic [CW-1:0]     cnt_d [TOT];
  logic              rsp_valid_q, rsp_valid_d;
  logic [BANK_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              irq_q, irq_d;

  logic              acc;
  logic              wr;
  logic [BANK_W-1:0] rd_data;
  logic [TOT-1:0]    w1c;
  logic [TOT-1:0]    synced;
  logic [TOT-1:0]    rise_evt;
  logic [TOT-1:0]    fall_evt;

  assign req_ready = !rsp_valid_q || rsp_ready;
  assign acc       = req_valid && req_ready;
  assign wr        = acc && req_we;
  assign synced    = sync_q[SYNC_STAGES-1];

  // Register file: reads see pre-update state; writes land on the accept edge.
  always_comb begin
    rd_data = '0;
    out_d   = out_q;
    oe_d    = oe_q;
    rise_d  = rise_q;
    fall_d  = fall_q;
    w1c     = '0;
    for (int b = 0; b < N_BANKS; b++) begin
      if (req_bank == BW'(b)) begin
        case (req_reg)
          3'd0: rd_data = out_q[b*BANK_W +: BANK_W];
          3'd1: rd_data = oe_q[b*BANK_W +: BANK_W];
          3'd2: rd_data = in_q[b*BANK_W +: BANK_W];
          3'd3: rd_data = rise_q[b*BANK_W +: BANK_W];
          3'd4: rd_data = fall_q[b*BANK_W +: BANK_W];
          3'd5: rd_data = pend_q[b*BANK_W +: BANK_W];
          default: rd_data = '0;
        endcase
        if (wr) begin
          case (req_reg)
            3'd0: out_d[b*BANK_W +: BANK_W]  = req_wdata;
            3'd1: oe_d[b*BANK_W +: BANK_W]   = req_wdata;
            3'd3: rise_d[b*BANK_W +: BANK_W] = req_wdata;
            3'd4: fall_d[b*BANK_W +: BANK_W] = req_wdata;
            3'd5: w1c[b*BANK_W +: BANK_W]    = req_wdata;
            default: ;
          endcase
        end
      end
    end
  end

  // Response channel: hold until consumed, reload on accept.
  always_comb begin
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    if (acc) begin
      rsp_valid_d = 1'b1;
      rsp_rdata_d = req_we ? '0 : rd_data;
    end else if (rsp_ready) begin
      rsp_valid_d = 1'b0;
    end
  end

  // Input synchroniser and debounce.
  always_comb begin
    sync_d[0] = pad_in;
    for (int i = 1; i < SYNC_STAGES; i++) begin
      sync_d[i] = sync_q[i-1];
    end
    in_d = in_q;
    for (int p = 0; p < TOT; p++) begin
      cnt_d[p] = '0;
    end
    if (DEBOUNCE_CYC == 0) begin
      // Bypass: IN tracks the last synchroniser stage in lockstep.
      in_d = sync_q[SYNC_STAGES-2];
    end else begin
      for (int p = 0; p < TOT; p++) begin
        if (synced[p] != in_q[p]) begin
          if (cnt_q[p] == CW'(DEBOUNCE_CYC - 1)) begin
            in_d[p] = synced[p];
          end else begin
            cnt_d[p] = cnt_q[p] + CW'(1);
          end
        end
      end
    end
  end

  // Edge detect on the debounced level; a new edge beats a same-cycle W1C.
  always_comb begin
    rise_evt = ~in_q & in_d & rise_q;
    fall_evt = in_q & ~in_d & fall_q;
    pend_d   = (pend_q & ~w1c) | rise_evt | fall_evt;
    irq_d    = |pend_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q       <= '0;
      oe_q        <= '0;
      in_q        <= '0;
      rise_q      <= '0;
      fall_q      <= '0;
      pend_q      <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      irq_q       <= 1'b0;
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= '0;
      end
      for (int p = 0; p < TOT; p++) begin
        cnt_q[p] <= '0;
      end
    end else begin
      out_q       <= out_d;
      oe_q        <= oe_d;
      in_q        <= in_d;
      rise_q      <= rise_d;
      fall_q      <= fall_d;
      pend_q      <= pend_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      irq_q       <= irq_d;
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_d[i];
      end
      for (int p = 0; p < TOT; p++) begin
        cnt_q[p] <= cnt_d[p];
      end
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign pad_out   = out_q;
  assign pad_oe    = oe_q;
  assign irq       = irq_q;

endmodule

// File: tb/tb_gpio_bank_ctrl.sv
// Purpose : exercises gpio_bank_ctrl register access, pad drive, debounce, interrupts and reset.
// Latency : responses are matched in order against a queue of expected read data.
// Backpressure: rsp_ready is held low in one sequence to check response hold and req_ready.
module tb_gpio_bank_ctrl;

  localparam int BANK_W = 36;
  localparam int NB     = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [0:0]        req_bank;
  logic [2:0]        req_reg;
  logic [BANK_W-1:0] req_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [BANK_W-1:0] rsp_rdata;
  logic [NB*BANK_W-1:0] pad_in;
  logic [NB*BANK_W-1:0] pad_out;
  logic [NB*BANK_W-1:0] pad_oe;
  logic              irq;

  int n_cmp = 0;
  int n_bad = 0;
  logic [BANK_W-1:0] exp_q [$];

  typedef struct {
    bit        we;
    int        bank;
    int        rg;
    bit [35:0] wdata;
    bit [35:0] exp;
  } vec_t;

  always #5 clk = ~clk;

  gpio_bank_ctrl #(.BANK_W(BANK_W), .N_BANKS(NB), .SYNC_STAGES(2), .DEBOUNCE_CYC(16)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_bank(req_bank), .req_reg(req_reg), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .pad_in(pad_in), .pad_out(pad_out), .pad_oe(pad_oe), .irq(irq)
  );

  task automatic check(input string nm, input logic [71:0] act, input logic [71:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drives one request; returns one time step after the accepting edge.
  task automatic send(input bit we, input int bank, input int rg,
                      input logic [35:0] wd, input logic [35:0] exp);
    int n;
    req_we    = we;
    req_bank  = 1'(bank);
    req_reg   = 3'(rg);
    req_wdata = wd;
    req_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      check("req_accept_timeout", 72'(req_ready), 72'd1);
    end else begin
      exp_q.push_back(exp);
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      check("drain_timeout", 72'(exp_q.size()), 72'd0);
      exp_q.delete();
    end
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: compare each response at the transfer cycle.
  initial begin
    logic [BANK_W-1:0] e;
    forever begin
      @(negedge clk);
      if (!rst && rsp_valid && rsp_ready) begin
        if (exp_q.size() == 0) begin
          check("rsp_unexpected", 72'(rsp_valid), 72'd0);
        end else begin
          e = exp_q.pop_front();
          check("rsp_rdata", 72'(rsp_rdata), 72'(e));
        end
      end
    end
  end

  initial begin
    vec_t vecs [18];
    int   ones;

    vecs[0]  = '{1, 0, 0, 36'h123456789, 36'h0};
    vecs[1]  = '{1, 0, 1, 36'hF0F0F0F0F, 36'h0};
    vecs[2]  = '{0, 0, 0, 36'h0,         36'h123456789};
    vecs[3]  = '{0, 0, 1, 36'h0,         36'hF0F0F0F0F};
    vecs[4]  = '{1, 1, 1, 36'h0000000FF, 36'h0};
    vecs[5]  = '{1, 1, 0, 36'h0000000A5, 36'h0};
    vecs[6]  = '{1, 1, 4, 36'hABCDE0123, 36'h0};
    vecs[7]  = '{0, 1, 4, 36'h0,         36'hABCDE0123};
    vecs[8]  = '{1, 1, 4, 36'h0,         36'h0};
    vecs[9]  = '{0, 0, 2, 36'h0,         36'h0};
    vecs[10] = '{0, 0, 5, 36'h0,         36'h0};
    vecs[11] = '{1, 0, 7, 36'hFFF,       36'h0};
    vecs[12] = '{1, 0, 6, 36'hFFF,       36'h0};
    vecs[13] = '{0, 0, 7, 36'h0,         36'h0};
    vecs[14] = '{0, 0, 6, 36'h0,         36'h0};
    vecs[15] = '{0, 0, 0, 36'h0,         36'h123456789};
    vecs[16] = '{1, 0, 5, 36'hFFFFFFFFF, 36'h0};
    vecs[17] = '{0, 1, 0, 36'h0,         36'h0000000A5};

    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_bank = '0; req_reg = '0;
    req_wdata = '0; rsp_ready = 1'b1; pad_in = '0;
    cyc(3);
    check("reset_rsp_valid", 72'(rsp_valid), 72'd0);
    check("reset_pad_out", pad_out, 72'd0);
    check("reset_pad_oe", pad_oe, 72'd0);
    check("reset_irq", 72'(irq), 72'd0);
    rst = 1'b0;
    cyc(2);
    check("idle_req_ready", 72'(req_ready), 72'd1);

    // Table-driven register accesses, back-to-back.
    foreach (vecs[i]) send(vecs[i].we, vecs[i].bank, vecs[i].rg, vecs[i].wdata, vecs[i].exp);
    drain();
    check("pads_out", pad_out, {36'h0000000A5, 36'h123456789});
    check("pads_oe", pad_oe, {36'h0000000FF, 36'hF0F0F0F0F});

    // Pad write visible one cycle after accept.
    send(1, 1, 1, 36'h1FF, 36'h0);
    check("oe_next_cycle", 72'(pad_oe[71:36]), 72'h1FF);
    send(1, 1, 1, 36'h0FF, 36'h0);
    check("oe_restore", 72'(pad_oe[71:36]), 72'hFF);
    drain();

    // Response held while rsp_ready is low.
    rsp_ready = 1'b0;
    send(0, 1, 0, 36'h0, 36'hA5);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("hold_rsp_valid", 72'(rsp_valid), 72'd1);
      check("hold_rsp_rdata", 72'(rsp_rdata), 72'hA5);
      check("hold_req_ready", 72'(req_ready), 72'd0);
    end
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    drain();

    // Debounce: accepted level after exactly 2 + 16 edges.
    @(posedge clk); #1;
    pad_in[0] = 1'b1;
    for (int k = 1; k <= 18; k++) begin
      @(posedge clk); #1;
      if (k == 17) check("deb_in_k17", 72'(dut.in_q[0]), 72'd0);
      if (k == 18) check("deb_in_k18", 72'(dut.in_q[0]), 72'd1);
    end
    cyc(2);
    pad_in[0] = 1'b0;
    cyc(20);
    check("deb_in_back0", 72'(dut.in_q[0]), 72'd0);
    pad_in[0] = 1'b1;
    cyc(10);
    pad_in[0] = 1'b0;
    ones = 0;
    for (int k = 0; k < 30; k++) begin
      @(posedge clk); #1;
      if (dut.in_q[0]) ones++;
    end
    check("deb_glitch_filtered", 72'(ones), 72'd0);
    send(0, 0, 2, 36'h0, 36'h0);
    drain();

    // Rising-edge interrupt on pin 0.
    send(1, 0, 3, 36'h1, 36'h0);
    send(1, 0, 4, 36'h0, 36'h0);
    drain();
    pad_in[0] = 1'b1;
    for (int k = 1; k <= 19; k++) begin
      @(posedge clk); #1;
      if (k == 18) check("irq_k18", 72'(irq), 72'd0);
      if (k == 19) check("irq_k19", 72'(irq), 72'd1);
    end
    send(0, 0, 5, 36'h0, 36'h1);
    pad_in[0] = 1'b0;
    cyc(25);
    send(0, 0, 5, 36'h0, 36'h1);
    drain();
    check("irq_after_fall", 72'(irq), 72'd1);
    send(1, 0, 5, 36'h1, 36'h0);
    check("irq_w1c_same", 72'(irq), 72'd1);
    @(posedge clk); #1;
    check("irq_w1c_drop", 72'(irq), 72'd0);
    send(0, 0, 5, 36'h0, 36'h0);
    drain();

    // Edge on a disabled pin never pends, even after enabling.
    pad_in[5] = 1'b1;
    cyc(25);
    send(1, 0, 3, 36'h29, 36'h0);
    send(0, 0, 5, 36'h0, 36'h0);
    drain();
    check("no_retro_irq", 72'(irq), 72'd0);

    // W1C collides with a new rising edge on pin 3.
    pad_in[3] = 1'b1;
    cyc(25);
    send(0, 0, 5, 36'h0, 36'h8);
    drain();
    pad_in[3] = 1'b0;
    cyc(25);
    @(posedge clk); #1;
    pad_in[3] = 1'b1;
    repeat (17) @(posedge clk);
    #1;
    send(1, 0, 5, 36'h8, 36'h0);
    check("coll_in3", 72'(dut.in_q[3]), 72'd1);
    check("coll_irq", 72'(irq), 72'd1);
    @(posedge clk); #1;
    check("coll_irq_next", 72'(irq), 72'd1);
    send(0, 0, 5, 36'h0, 36'h8);
    drain();

    // Async reset with a response outstanding.
    pad_in = '0;
    cyc(25);
    rsp_ready = 1'b0;
    send(0, 1, 0, 36'h0, 36'hA5);
    @(posedge clk); #2;
    check("pre_rst_irq", 72'(irq), 72'd1);
    rst = 1'b1;
    #1;
    check("rst_rsp_valid", 72'(rsp_valid), 72'd0);
    check("rst_pad_oe", pad_oe, 72'd0);
    check("rst_irq", 72'(irq), 72'd0);
    check("rst_rsp_rdata", 72'(rsp_rdata), 72'd0);
    exp_q.delete();
    cyc(2);
    rst = 1'b0;
    rsp_ready = 1'b1;
    for (int b = 0; b < NB; b++) begin
      for (int r = 0; r < 8; r++) begin
        send(0, b, r, 36'h0, 36'h0);
      end
    end
    drain();
    check("post_rst_pad_out", pad_out, 72'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
